ws2812_frame_scheduler: RTL and testbench



---
 rtl/ws2812_pkg.sv | 21 ++
 rtl/ws2812_pixel_ram.sv | 38 +++
 rtl/ws2812_frame_scheduler.sv | 167 ++++++++++++++++
 tb/tb_ws2812_frame_scheduler.sv | 326 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ws2812_pkg.sv
// Shared types and helpers for the WS2812 frame scheduler and its pixel RAM.
package ws2812_pkg;

   localparam int WS2812_WIDTH = 24;

   typedef logic [WS2812_WIDTH-1:0] pixel_t;

   typedef enum logic [2:0] {
      IDLE,
      LOAD,
      OFFER,
      DRAIN,
      GAP
   } sched_state_t;

   // Latch gap length in clock cycles for a given clock frequency and gap time.
   function automatic int gap_cycles(input int clk_fre, input int reset_us);
      return clk_fre / 1_000_000 * reset_us;
   endfunction

endpackage

// File: rtl/ws2812_pixel_ram.sv
// Simple dual-port pixel buffer: one write port, one registered read-first read port.
module ws2812_pixel_ram
   import ws2812_pkg::*;
#(
   parameter int DEPTH = 256,
   parameter int AW    = $clog2(DEPTH)
)(
   input  logic          clk,
   input  logic          reset_n,
   input  logic          wr_en,
   input  logic [AW-1:0] wr_addr,
   input  pixel_t        wr_data,
   input  logic          rd_en,
   input  logic [AW-1:0] rd_addr,
   output pixel_t        rd_data
);

   pixel_t mem [DEPTH];
   pixel_t rd_data_q;

   always_ff @(posedge clk) begin
      if (wr_en) begin
         mem[wr_addr] <= wr_data;
      end
   end

   // Read register holds its word between reads so the offered pixel stays stable.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         rd_data_q <= '0;
      end else if (rd_en) begin
         rd_data_q <= mem[rd_addr];
      end
   end

   assign rd_data = rd_data_q;

endmodule

// File: rtl/ws2812_frame_scheduler.sv
// Frame scheduler: streams buffered GRB pixels to the serializer, then holds the latch gap.
// Optional macro WS2812_DOUBLE_BUFFER_EN adds a back bank swapped at each frame start.
module ws2812_frame_scheduler
   import ws2812_pkg::*;
#(
   parameter int CLK_FRE    = 27_000_000,
   parameter int RESET_US   = 80,
   parameter int MAX_PIXELS = 256
)(
   input  logic                    clk,
   input  logic                    reset_n,
   input  logic                    wr_en,
   input  logic [7:0]              wr_addr,
   input  logic [WS2812_WIDTH-1:0] wr_data,
   input  logic                    commit,
   input  logic [7:0]              number_of_pixels,
   output logic                    px_valid,
   output logic [WS2812_WIDTH-1:0] px_data,
   input  logic                    px_ready,
   input  logic                    tx_idle,
   output logic                    busy,
   output logic                    frame_done
`ifdef WS2812_DOUBLE_BUFFER_EN
   ,output logic                   front_bank
`endif
);

   localparam int GAP_CYCLES = gap_cycles(CLK_FRE, RESET_US);
   localparam int GAP_W      = $clog2(GAP_CYCLES + 1);

   sched_state_t     state_q, state_d;
   logic [8:0]       cnt_q, cnt_d;
   logic [7:0]       last_q, last_d;
   logic [GAP_W-1:0] gap_q, gap_d;
   logic             pending_q, pending_d;
   logic             px_valid_q, px_valid_d;
   logic             busy_q, busy_d;
   logic             frame_done_q, frame_done_d;
   logic             rd_en;
`ifdef WS2812_DOUBLE_BUFFER_EN
   logic             front_bank_q, front_bank_d;
`endif

   always_comb begin
      state_d      = state_q;
      cnt_d        = cnt_q;
      last_d       = last_q;
      gap_d        = gap_q;
      pending_d    = pending_q;
      px_valid_d   = px_valid_q;
      frame_done_d = 1'b0;
`ifdef WS2812_DOUBLE_BUFFER_EN
      front_bank_d = front_bank_q;
`endif
      unique case (state_q)
         IDLE: begin
            if (commit || pending_q) begin
               state_d   = LOAD;
               last_d    = number_of_pixels;
               pending_d = 1'b0;
               cnt_d     = '0;
`ifdef WS2812_DOUBLE_BUFFER_EN
               front_bank_d = ~front_bank_q;
`endif
            end
         end
         LOAD: begin
            state_d    = OFFER;
            px_valid_d = 1'b1;
         end
         OFFER: begin
            if (px_valid_q && px_ready) begin
               px_valid_d = 1'b0;
               cnt_d      = cnt_q + 1'b1;
               state_d    = (cnt_q == {1'b0, last_q}) ? DRAIN : LOAD;
            end
         end
         DRAIN: begin
            if (tx_idle) begin
               gap_d   = '0;
               state_d = GAP;
            end
         end
         GAP: begin
            if (gap_q == GAP_W'(GAP_CYCLES - 1)) begin
               frame_done_d = 1'b1;
               state_d      = IDLE;
            end else begin
               gap_d = gap_q + 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase
      // Commits seen outside IDLE collapse into a single queued frame.
      if (state_q != IDLE && commit) begin
         pending_d = 1'b1;
      end
      busy_d = (state_d != IDLE);
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q      <= IDLE;
         cnt_q        <= '0;
         last_q       <= '0;
         gap_q        <= '0;
         pending_q    <= 1'b0;
         px_valid_q   <= 1'b0;
         busy_q       <= 1'b0;
         frame_done_q <= 1'b0;
`ifdef WS2812_DOUBLE_BUFFER_EN
         front_bank_q <= 1'b0;
`endif
      end else begin
         state_q      <= state_d;
         cnt_q        <= cnt_d;
         last_q       <= last_d;
         gap_q        <= gap_d;
         pending_q    <= pending_d;
         px_valid_q   <= px_valid_d;
         busy_q       <= busy_d;
         frame_done_q <= frame_done_d;
`ifdef WS2812_DOUBLE_BUFFER_EN
         front_bank_q <= front_bank_d;
`endif
      end
   end

   assign rd_en = (state_q == LOAD);

`ifdef WS2812_DOUBLE_BUFFER_EN
   pixel_t rd_data [2];

   // Host always writes the bank that is not being streamed.
   for (genvar gi = 0; gi < 2; gi++) begin : g_bank
      ws2812_pixel_ram #(.DEPTH(MAX_PIXELS)) u_ram (
         .clk     (clk),
         .reset_n (reset_n),
         .wr_en   (wr_en && (front_bank_q != 1'(gi))),
         .wr_addr (wr_addr),
         .wr_data (wr_data),
         .rd_en   (rd_en && (front_bank_q == 1'(gi))),
         .rd_addr (cnt_q[7:0]),
         .rd_data (rd_data[gi])
      );
   end

   assign px_data    = rd_data[front_bank_q];
   assign front_bank = front_bank_q;
`else
   ws2812_pixel_ram #(.DEPTH(MAX_PIXELS)) u_ram (
      .clk     (clk),
      .reset_n (reset_n),
      .wr_en   (wr_en),
      .wr_addr (wr_addr),
      .wr_data (wr_data),
      .rd_en   (rd_en),
      .rd_addr (cnt_q[7:0]),
      .rd_data (px_data)
   );
`endif

   assign px_valid   = px_valid_q;
   assign busy       = busy_q;
   assign frame_done = frame_done_q;

endmodule

// File: tb/tb_ws2812_frame_scheduler.sv
// Self-checking bench for ws2812_frame_scheduler: frame table plus reset and bank-swap sequences.
module tb_ws2812_frame_scheduler;

   localparam int G = 27_000_000 / 1_000_000 * 80;

   logic        clk = 1'b0;
   logic        reset_n = 1'b0;
   logic        wr_en = 1'b0;
   logic [7:0]  wr_addr = '0;
   logic [23:0] wr_data = '0;
   logic        commit = 1'b0;
   logic [7:0]  number_of_pixels = '0;
   logic        px_valid;
   logic [23:0] px_data;
   logic        px_ready = 1'b1;
   logic        tx_idle = 1'b1;
   logic        busy;
   logic        frame_done;
`ifdef WS2812_DOUBLE_BUFFER_EN
   logic        front_bank;
   localparam bit DB = 1'b1;
`else
   localparam bit DB = 1'b0;
`endif

   ws2812_frame_scheduler dut (
      .clk              (clk),
      .reset_n          (reset_n),
      .wr_en            (wr_en),
      .wr_addr          (wr_addr),
      .wr_data          (wr_data),
      .commit           (commit),
      .number_of_pixels (number_of_pixels),
      .px_valid         (px_valid),
      .px_data          (px_data),
      .px_ready         (px_ready),
      .tx_idle          (tx_idle),
      .busy             (busy),
      .frame_done       (frame_done)
`ifdef WS2812_DOUBLE_BUFFER_EN
      ,.front_bank      (front_bank)
`endif
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [23:0] data;
      bit          last;
   } exp_t;

   typedef struct {
      int last;
      int mode;
      int stall_px;
      int stall_len;
      int extra;
      int exp_xfers;
      int exp_frames;
   } vec_t;

   exp_t        sb_q[$];
   logic [23:0] mdl [2][256];
   int          mfront = 0;
   int          n_checks = 0;
   int          n_fail = 0;
   int          cyc = 0;
   int          xfer_total = 0;
   int          frames_done = 0;
   int          exp_done_cyc = 0;
   bit          done_armed = 1'b0;
   bit          restart_expected = 1'b0;
   bit          prev_done = 1'b0;
   int          dcnt = 0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic host_write(input int a, input logic [23:0] d);
      wr_en   = 1'b1;
      wr_addr = a[7:0];
      wr_data = d;
      tick();
      wr_en   = 1'b0;
      mdl[DB ? 1 - mfront : 0][a] = d;
   endtask

   task automatic push_frame(input int last);
      if (DB) mfront = 1 - mfront;
      for (int i = 0; i <= last; i++) begin
         sb_q.push_back('{data: mdl[DB ? mfront : 0][i], last: (i == last)});
      end
   endtask

   task automatic start_frame(input int last);
      number_of_pixels = last[7:0];
      commit = 1'b1;
      tick();
      commit = 1'b0;
      push_frame(last);
      $display("frame start: last_idx=%0d", last);
   endtask

   task automatic wait_offer(input int target);
      int t = 0;
      while (!(xfer_total == target && px_valid === 1'b1) && t < 5000) begin
         tick();
         t++;
      end
      if (t >= 5000) begin
         n_checks++;
         n_fail++;
         $display("FAIL wait_offer: got no offer, expected offer of transfer %0d", target);
      end
   endtask

   task automatic wait_frames(input int target);
      int t = 0;
      while (frames_done < target && t < 12000) begin
         tick();
         t++;
      end
   endtask

   // Monitor: scoreboard pops, frame_done timing, serializer idle model.
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (reset_n) begin
            if (restart_expected && prev_done) begin
               check("pending_start_busy", 32'(busy), 32'd1);
               restart_expected = 1'b0;
            end
            prev_done = frame_done;
            if (frame_done) begin
               check("frame_done_expected", 32'(done_armed), 32'd1);
               if (done_armed) check("frame_done_time", 32'(cyc), 32'(exp_done_cyc));
               $display("frame_done at cycle %0d", cyc);
               done_armed = 1'b0;
               frames_done++;
            end
            if (px_valid && px_ready) begin
               check("busy_during_xfer", 32'(busy), 32'd1);
               if (sb_q.size() == 0) begin
                  n_checks++;
                  n_fail++;
                  $display("FAIL extra_transfer: got px_data 0x%06h, expected no transfer", px_data);
               end else begin
                  e = sb_q.pop_front();
                  check("px_data", 32'(px_data), 32'(e.data));
                  $display("xfer %0d: px_data=0x%06h expected=0x%06h", xfer_total, px_data, e.data);
                  if (e.last) begin
                     done_armed   = 1'b1;
                     exp_done_cyc = cyc + G + 3;
                  end
               end
               xfer_total++;
               dcnt    = 2;
               tx_idle = 1'b0;
            end else if (dcnt > 0) begin
               dcnt--;
               if (dcnt == 0) tx_idle = 1'b1;
            end
         end else begin
            dcnt      = 0;
            tx_idle   = 1'b1;
            prev_done = 1'b0;
         end
      end
   end

   task automatic run_frame(input vec_t v);
      logic [23:0] pix [256];
      logic [23:0] fixed3 [3];
      int base;
      int fbase;
      bit ok;
      logic [7:0] i8;
      fixed3[0] = 24'h00FF00;
      fixed3[1] = 24'hFF0000;
      fixed3[2] = 24'h0000FF;
      for (int i = 0; i <= v.last; i++) begin
         i8 = 8'(i);
         case (v.mode)
            0:       pix[i] = fixed3[i % 3];
            1:       pix[i] = 24'($urandom);
            default: pix[i] = {i8, ~i8, i8 ^ 8'h3C};
         endcase
         host_write(i, pix[i]);
      end
      base  = xfer_total;
      fbase = frames_done;
      start_frame(v.last);
`ifdef WS2812_DOUBLE_BUFFER_EN
      check("front_bank_start", 32'(front_bank), 32'(mfront));
`endif
      number_of_pixels = v.last[7:0] ^ 8'hA5;
      if (v.stall_px >= 0) begin
         wait_offer(base + v.stall_px);
         px_ready = 1'b0;
         ok = 1'b1;
         repeat (v.stall_len) begin
            tick();
            if (!(px_valid === 1'b1 && sb_q.size() > 0 && px_data === sb_q[0].data)) ok = 1'b0;
         end
         check("stall_hold", 32'(ok), 32'd1);
         px_ready = 1'b1;
      end
      if (v.extra > 0) begin
         repeat (4) tick();
         number_of_pixels = v.last[7:0];
         for (int i = 0; i <= v.last; i++) host_write(i, pix[i]);
         for (int k = 0; k < v.extra; k++) begin
            commit = 1'b1;
            tick();
            commit = 1'b0;
            repeat (3) tick();
         end
         push_frame(v.last);
         restart_expected = 1'b1;
      end
      wait_frames(fbase + v.exp_frames);
      repeat (3) tick();
      check("xfer_count", 32'(xfer_total - base), 32'(v.exp_xfers));
      check("frame_count", 32'(frames_done - fbase), 32'(v.exp_frames));
      check("busy_after_frame", 32'(busy), 32'd0);
      check("scoreboard_empty", 32'(sb_q.size()), 32'd0);
   endtask

   initial begin
      vec_t vecs [5];
      vec_t vr;
      int base;
      int fbase;
`ifdef WS2812_DOUBLE_BUFFER_EN
      logic fb_prev;
`endif
      vecs[0] = '{2,   0, -1, 0,   0, 3,   1};
      vecs[1] = '{7,   2,  4, 100, 0, 8,   1};
      vecs[2] = '{0,   1, -1, 0,   0, 1,   1};
      vecs[3] = '{255, 1, -1, 0,   0, 256, 1};
      vecs[4] = '{15,  2, -1, 0,   3, 32,  2};
      vr      = '{9,   1, -1, 0,   0, 10,  1};

      #2;
      check("reset_px_valid", 32'(px_valid), 32'd0);
      check("reset_px_data", 32'(px_data), 32'd0);
      check("reset_busy", 32'(busy), 32'd0);
      check("reset_frame_done", 32'(frame_done), 32'd0);
`ifdef WS2812_DOUBLE_BUFFER_EN
      check("reset_front_bank", 32'(front_bank), 32'd0);
`endif
      repeat (3) tick();
      reset_n = 1'b1;
      repeat (2) tick();

      for (int v = 0; v < 5; v++) begin
         $display("vector %0d: last=%0d stall_px=%0d extra_commits=%0d", v, vecs[v].last, vecs[v].stall_px, vecs[v].extra);
         run_frame(vecs[v]);
      end

      // Reset while pixel 5 is being offered and held.
      for (int i = 0; i <= 9; i++) host_write(i, 24'($urandom) | 24'h000001);
      base = xfer_total;
      start_frame(9);
      wait_offer(base + 5);
      px_ready = 1'b0;
      #2;
      reset_n = 1'b0;
      #1;
      check("midreset_px_valid", 32'(px_valid), 32'd0);
      check("midreset_busy", 32'(busy), 32'd0);
      check("midreset_px_data", 32'(px_data), 32'd0);
      check("midreset_frame_done", 32'(frame_done), 32'd0);
      sb_q.delete();
      done_armed = 1'b0;
      mfront     = 0;
      fbase      = frames_done;
      repeat (3) tick();
      reset_n  = 1'b1;
      px_ready = 1'b1;
      repeat (5) tick();
      check("no_done_after_reset", 32'(frames_done - fbase), 32'd0);
      $display("post-reset frame");
      run_frame(vr);

`ifdef WS2812_DOUBLE_BUFFER_EN
      // Write during a frame lands in the back bank and shows up one frame later.
      for (int i = 0; i <= 2; i++) host_write(i, 24'hA00000 + 24'(i));
      fbase = frames_done;
      start_frame(2);
      fb_prev = front_bank;
      host_write(1, 24'h123456);
      wait_frames(fbase + 1);
      repeat (3) tick();
      check("db_frame1_count", 32'(frames_done - fbase), 32'd1);
      host_write(0, 24'hB00000);
      host_write(2, 24'hB00002);
      fbase = frames_done;
      start_frame(2);
      check("db_front_toggle", 32'(front_bank), 32'(~fb_prev));
      wait_frames(fbase + 1);
      repeat (3) tick();
      check("db_frame2_count", 32'(frames_done - fbase), 32'd1);
      check("db_front_stable", 32'(front_bank), 32'(~fb_prev));
      check("db_scoreboard_empty", 32'(sb_q.size()), 32'd0);
`endif

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
